// File: rtl/pll_ctrl_pkg.sv
// pll_ctrl_pkg: shared state encoding and default timing constants for the PLL sequencer
package pll_ctrl_pkg;
  typedef enum logic [2:0] {RESET, WAIT_LOCK, STABLE, RUN, PH_LOW, PH_GAP, PH_END} state_t;
  localparam int DEF_RST_CYCLES     = 16;
  localparam int DEF_STABLE_CYCLES  = 1024;
  localparam int DEF_TIMEOUT_CYCLES = 65536;
  localparam int DEF_STEP_LOW       = 4;
  localparam int DEF_STEP_GAP       = 4;
  // Counter width for the largest cycle count plus one bit of headroom
  function automatic int cnt_width(input int a, input int b, input int c, input int d, input int e);
    int m;
    m = a;
    m = b > m ? b : m;
    m = c > m ? c : m;
    m = d > m ? d : m;
    m = e > m ? e : m;
    return $clog2(m) + 1;
  endfunction
endpackage

// File: rtl/sync2.sv
// sync2: two-flop synchronizer for a single asynchronous level
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic meta;
  // Shift the level through two flops to settle metastability
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {q, meta} <= 2'b00;
    else {q, meta} <= {meta, d};
endmodule

// File: rtl/pll_lock_seq.sv
// pll_lock_seq: ECP5 PLL reset/lock sequencer with dynamic phase-step control
module pll_lock_seq
  import pll_ctrl_pkg::*;
#(
  parameter int RST_CYCLES     = DEF_RST_CYCLES,
  parameter int STABLE_CYCLES  = DEF_STABLE_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int STEP_LOW       = DEF_STEP_LOW,
  parameter int STEP_GAP       = DEF_STEP_GAP
) (
  input  logic       clkin,
  input  logic       rst_n,
  input  logic       pll_locked,
  output logic       pll_rst,
  output logic       sys_rst_n,
  output logic       ready,
  input  logic       phase_req,
  input  logic [1:0] phase_sel,
  input  logic       phase_dir,
  input  logic [7:0] phase_count,
  output logic       phase_busy,
  output logic       phase_ack,
  output logic [1:0] pll_phasesel,
  output logic       pll_phasedir,
  output logic       pll_phasestep,
  output logic       pll_phaseloadreg,
  output logic [7:0] loss_count
);
  localparam int CW = cnt_width(RST_CYCLES, STABLE_CYCLES, TIMEOUT_CYCLES, STEP_LOW, STEP_GAP);
  logic          lock_s, lost, ack_n, dir_n;
  logic [1:0]    sel_n;
  logic [7:0]    rem, rem_n;
  logic [CW-1:0] cnt, cnt_n;
  state_t        state, state_n;
  sync2 u_sync (.clk(clkin), .rst_n(rst_n), .d(pll_locked), .q(lock_s));
  // Next state, shared counter and captured phase parameters; lock loss overrides everything
  always_comb begin
    state_n = state;
    rem_n   = rem;
    sel_n   = pll_phasesel;
    dir_n   = pll_phasedir;
    ack_n   = 1'b0;
    lost    = !lock_s && (state inside {RUN, PH_LOW, PH_GAP, PH_END});
    if (lost) state_n = RESET;
    else
      case (state)
        RESET:     state_n = cnt == CW'(RST_CYCLES - 1) ? WAIT_LOCK : RESET;
        WAIT_LOCK: state_n = lock_s ? STABLE : cnt == CW'(TIMEOUT_CYCLES - 1) ? RESET : WAIT_LOCK;
        STABLE:    state_n = !lock_s ? WAIT_LOCK : cnt == CW'(STABLE_CYCLES) ? RUN : STABLE;
        RUN:
          if (phase_req) begin
            sel_n   = phase_sel;
            dir_n   = phase_dir;
            rem_n   = phase_count;
            ack_n   = phase_count == 8'd0;
            state_n = phase_count == 8'd0 ? RUN : PH_LOW;
          end
        PH_LOW:
          if (cnt == CW'(STEP_LOW - 1)) begin
            rem_n   = rem - 8'd1;
            state_n = rem == 8'd1 ? PH_END : PH_GAP;
          end
        PH_GAP:    state_n = cnt == CW'(STEP_GAP - 1) ? PH_LOW : PH_GAP;
        PH_END: begin
          ack_n   = cnt == CW'(STEP_GAP);
          state_n = ack_n ? RUN : PH_END;
        end
        default:   state_n = RESET;
      endcase
    cnt_n = (state_n != state || state == RUN) ? '0 : cnt + 1'b1;
  end
  // Register state and every output; phasestep lags the state by one cycle so select/direction settle first
  always_ff @(posedge clkin or negedge rst_n)
    if (!rst_n) begin
      state            <= RESET;
      cnt              <= '0;
      rem              <= 8'd0;
      pll_rst          <= 1'b1;
      sys_rst_n        <= 1'b0;
      ready            <= 1'b0;
      phase_busy       <= 1'b0;
      phase_ack        <= 1'b0;
      pll_phasesel     <= 2'd0;
      pll_phasedir     <= 1'b0;
      pll_phasestep    <= 1'b1;
      pll_phaseloadreg <= 1'b1;
      loss_count       <= 8'd0;
    end else begin
      state            <= state_n;
      cnt              <= cnt_n;
      rem              <= rem_n;
      pll_rst          <= state_n == RESET;
      sys_rst_n        <= state_n inside {RUN, PH_LOW, PH_GAP, PH_END};
      ready            <= state_n inside {RUN, PH_LOW, PH_GAP, PH_END};
      phase_busy       <= state_n inside {PH_LOW, PH_GAP, PH_END};
      phase_ack        <= ack_n;
      pll_phasesel     <= sel_n;
      pll_phasedir     <= dir_n;
      pll_phasestep    <= !(state == PH_LOW && !lost);
      pll_phaseloadreg <= 1'b1;
      loss_count       <= (lost && loss_count != 8'hff) ? loss_count + 8'd1 : loss_count;
    end
endmodule
